// File: rtl/pwm_cook_controller_pkg.sv
// Shared definitions for the microwave PWM cook sequencer: FSM state encodings.
package pwm_cook_controller_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_COOK  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_cook_controller_tick_divider.sv
// Modulo-MOD counter. wrap is high (combinationally) on the enabled cycle whose edge rolls
// the count from MOD-1 back to 0, so the parent can register a pulse aligned with that edge.
module tick_divider
  import pwm_cook_controller_pkg::*;
#(
  parameter int MOD = 16
) (
  input  logic clock,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int CW = (MOD > 1) ? $clog2(MOD) : 1;

  logic [CW-1:0] count;
  logic          last;

  assign last = (count == CW'(MOD - 1));
  assign wrap = en && !clr && last;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_cook_controller.sv
// Cook sequencer: FSM, remaining-seconds counter and glitch-free duty register feeding the
// PWM counter. Handshake: start/stop/clear are single-cycle strobes; door_open is a level.
module pwm_cook_controller
  import pwm_cook_controller_pkg::*;
#(
  parameter int NUM_BITS      = 4,
  parameter int SEC_BITS      = 8,
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                door_open,
  input  logic [SEC_BITS-1:0] cook_secs,
  input  logic [NUM_BITS-1:0] power_level,
  output logic                pwm_en,
  output logic [NUM_BITS-1:0] duty,
  output logic                period_rst,
  output logic                sec_tick,
  output logic [SEC_BITS-1:0] remaining,
  output logic                done,
  output logic                beep,
  output logic [STATE_W-1:0]  state
);

  state_t              state_q, state_d;
  logic [SEC_BITS-1:0] remaining_d;
  logic [NUM_BITS-1:0] duty_d;
  logic                cook_en, cnt_clr, per_wrap, sec_wrap;

  assign state   = state_q;
  assign cook_en = (state_q == S_COOK);
  assign cnt_clr = (state_q == S_IDLE);

  tick_divider #(.MOD(2 ** NUM_BITS)) u_period (
    .clock (clock),
    .resetn(resetn),
    .en    (cook_en),
    .clr   (cnt_clr),
    .wrap  (per_wrap)
  );

  tick_divider #(.MOD(TICKS_PER_SEC)) u_second (
    .clock (clock),
    .resetn(resetn),
    .en    (cook_en),
    .clr   (cnt_clr),
    .wrap  (sec_wrap)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining;
    duty_d      = duty;
    case (state_q)
      S_IDLE: begin
        duty_d = power_level;
        if (!clear && start && (cook_secs != '0) && !door_open) begin
          state_d     = S_COOK;
          remaining_d = cook_secs;
        end
      end
      S_COOK: begin
        if (per_wrap) duty_d = power_level;
        if (clear) begin
          state_d = S_IDLE;
        end else begin
          // A second boundary is honoured even when stop/door arrive on the same edge.
          if (sec_wrap) remaining_d = (remaining == '0) ? '0 : remaining - 1'b1;
          if (sec_wrap && (remaining <= SEC_BITS'(1))) state_d = S_DONE;
          else if (stop || door_open)                  state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (clear)                                state_d = S_IDLE;
        else if (start && !stop && !door_open)    state_d = S_COOK;
      end
      S_DONE: begin
        if (clear) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) remaining_d = '0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      remaining  <= '0;
      duty       <= '0;
      pwm_en     <= 1'b0;
      beep       <= 1'b0;
      done       <= 1'b0;
      period_rst <= 1'b0;
      sec_tick   <= 1'b0;
    end else begin
      state_q    <= state_d;
      remaining  <= remaining_d;
      duty       <= duty_d;
      pwm_en     <= (state_d == S_COOK);
      beep       <= (state_d == S_DONE);
      done       <= (state_q == S_COOK) && (state_d == S_DONE);
      period_rst <= per_wrap && !clear;
      sec_tick   <= sec_wrap && !clear;
    end
  end

endmodule

// File: tb/tb_pwm_cook_controller.sv
// Directed bench for pwm_cook_controller with a 20-cycle second and a 16-cycle PWM period.
module tb_pwm_cook_controller;

  logic       clock;
  logic       resetn;
  logic       start, stop, clear, door_open;
  logic [7:0] cook_secs;
  logic [3:0] power_level;
  logic       pwm_en, period_rst, sec_tick, done, beep;
  logic [3:0] duty;
  logic [7:0] remaining;
  logic [1:0] state;

  int tests  = 0;
  int failed = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic       start, stop, clear, door;
    logic [7:0] cook;
    logic [3:0] power;
    int         wait_cyc;
    logic [1:0] e_state;
    logic [7:0] e_rem;
    logic       e_pwm, e_beep;
    logic [3:0] e_duty;
  } vec_t;

  vec_t vecs[10];

  pwm_cook_controller #(
    .NUM_BITS(4), .SEC_BITS(8), .TICKS_PER_SEC(20)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .stop       (stop),
    .clear      (clear),
    .door_open  (door_open),
    .cook_secs  (cook_secs),
    .power_level(power_level),
    .pwm_en     (pwm_en),
    .duty       (duty),
    .period_rst (period_rst),
    .sec_tick   (sec_tick),
    .remaining  (remaining),
    .done       (done),
    .beep       (beep),
    .state      (state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] secs, input logic [3:0] pwr);
    cook_secs   = secs;
    power_level = pwr;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    logic [12:0] exp_pk, act_pk;
    int          n;
    logic        duty_bad;

    resetn = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; door_open = 1'b0;
    cook_secs = 8'd0; power_level = 4'd0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd8, 2, 2'd3, 8'd0, 1'b0, 1'b1, 4'd8};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 4'd8, 1, 2'd0, 8'd0, 1'b0, 1'b0, 4'd8};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 4'd8, 1, 2'd0, 8'd0, 1'b0, 1'b0, 4'd8};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 4'd8, 1, 2'd0, 8'd0, 1'b0, 1'b0, 4'd8};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 4'd4, 3, 2'd1, 8'd5, 1'b1, 1'b0, 4'd4};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd5, 4'd4, 2, 2'd2, 8'd5, 1'b0, 1'b0, 4'd4};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 4'd4, 1, 2'd2, 8'd5, 1'b0, 1'b0, 4'd4};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd5, 4'd4, 0, 2'd1, 8'd5, 1'b1, 1'b0, 4'd4};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd5, 4'd4, 0, 2'd2, 8'd5, 1'b0, 1'b0, 4'd4};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd5, 4'd4, 1, 2'd0, 8'd0, 1'b0, 1'b0, 4'd4};

    // Reset values while resetn is held low
    repeat (3) step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_remaining", 32'(remaining), 32'd0);
    check("rst_duty", 32'(duty), 32'd0);
    check("rst_pulses", 32'({pwm_en, beep, done, period_rst, sec_tick}), 32'd0);
    resetn = 1'b1;
    step();

    // Full cook: 3 s at power 8, per-cycle expected pulses and countdown
    do_start(8'd3, 4'd8);
    check("t1_state_cook", 32'(state), 32'd1);
    check("t1_duty", 32'(duty), 32'd8);
    exp_q.push_back(8'd2); exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    for (int k = 1; k <= 70; k++) begin
      step();
      exp_pk = {((k % 16) == 0) && (k <= 48), (k == 20) || (k == 40) || (k == 60),
                k == 60, k < 60, k >= 60,
                (k < 20) ? 8'd3 : (k < 40) ? 8'd2 : (k < 60) ? 8'd1 : 8'd0};
      act_pk = {period_rst, sec_tick, done, pwm_en, beep, remaining};
      check($sformatf("t1_cycle%0d", k), 32'(act_pk), 32'(exp_pk));
      if (sec_tick) begin
        if (exp_q.size() > 0) check("t1_tick_remaining", 32'(remaining), 32'(exp_q.pop_front()));
        else check("t1_extra_tick", 32'd1, 32'd0);
      end
    end
    check("t1_ticks_left", 32'(exp_q.size()), 32'd0);
    check("t1_state_done", 32'(state), 32'd3);

    // Table: DONE ignores start, clear, ignored starts in IDLE, pause/resume/door paths
    for (int i = 0; i < 10; i++) begin
      start = vecs[i].start; stop = vecs[i].stop; clear = vecs[i].clear;
      door_open = vecs[i].door; cook_secs = vecs[i].cook; power_level = vecs[i].power;
      step();
      start = 1'b0; stop = 1'b0; clear = 1'b0;
      repeat (vecs[i].wait_cyc) step();
      check($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].e_state));
      check($sformatf("v%0d_remaining", i), 32'(remaining), 32'(vecs[i].e_rem));
      check($sformatf("v%0d_pwm_en", i), 32'(pwm_en), 32'(vecs[i].e_pwm));
      check($sformatf("v%0d_beep", i), 32'(beep), 32'(vecs[i].e_beep));
      check($sformatf("v%0d_duty", i), 32'(duty), 32'(vecs[i].e_duty));
    end

    // Stop at cycle 30, resume at cycle 50, partial second continues
    do_start(8'd3, 4'd8);
    repeat (29) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t2_state_pause", 32'(state), 32'd2);
    check("t2_remaining", 32'(remaining), 32'd2);
    check("t2_pwm_en", 32'(pwm_en), 32'd0);
    repeat (19) step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("t2_state_resume", 32'(state), 32'd1);
    n = 0;
    while (n < 30 && !sec_tick) begin
      step();
      n++;
    end
    check("t2_tick_delay", 32'(n), 32'd10);
    check("t2_remaining_tick", 32'(remaining), 32'd1);
    do_clear();

    // Power change mid-period takes effect only at the next period_rst
    do_start(8'd9, 4'd8);
    repeat (5) step();
    power_level = 4'd12;
    duty_bad = 1'b0;
    n = 0;
    while (n < 40 && !period_rst) begin
      step();
      n++;
      if (!period_rst && duty != 4'd8) duty_bad = 1'b1;
    end
    check("t4_duty_held", 32'(duty_bad), 32'd0);
    check("t4_period_delay", 32'(n), 32'd11);
    check("t4_duty_new", 32'(duty), 32'd12);
    do_clear();

    // Stop coincident with the final second: DONE wins
    do_start(8'd1, 4'd8);
    repeat (19) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("t6a_state", 32'(state), 32'd3);
    check("t6a_done", 32'(done), 32'd1);
    check("t6a_remaining", 32'(remaining), 32'd0);
    check("t6a_pwm_en", 32'(pwm_en), 32'd0);
    step();
    check("t6a_done_one_cycle", 32'(done), 32'd0);
    do_clear();
    check("t6a_beep_cleared", 32'(beep), 32'd0);

    // Clear coincident with a second wrap: IDLE, no done
    do_start(8'd3, 4'd8);
    repeat (19) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t6b_state", 32'(state), 32'd0);
    check("t6b_remaining", 32'(remaining), 32'd0);
    check("t6b_done", 32'(done), 32'd0);
    step();
    check("t6b_done_after", 32'(done), 32'd0);

    // Asynchronous reset mid-cook
    do_start(8'd5, 4'd8);
    repeat (7) step();
    check("t6c_precond", 32'(state), 32'd1);
    resetn = 1'b0;
    #1;
    check("t6c_state", 32'(state), 32'd0);
    check("t6c_remaining", 32'(remaining), 32'd0);
    check("t6c_duty", 32'(duty), 32'd0);
    check("t6c_pulses", 32'({pwm_en, beep, done, period_rst, sec_tick}), 32'd0);
    step();
    resetn = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
